t03_mem_bus_arbiter: RTL

- Shares one single-ported memory bus between the CPU instruction-fetch port and the data load/store port.
- Data accesses that fall in the top-of-address IO window are routed to the memory-mapped IO block and never reach the memory bus.
- Sequences each bus transaction with a one-cycle command strobe, a busy-wait and a timeout.
- Drives the CPU stall line while any request is outstanding.

---
 rtl/t03_mem_bus_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/t03_mem_bus_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data load/store.
// Data accesses in the top-of-address IO window are served by the IO block instead.
module t03_mem_bus_arbiter #(
   parameter logic [31:0] IO_BASE = 32'hFFFF_FFFC,
   parameter int          TIMEOUT = 255,
   parameter int          CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        err,
   output logic        bus_read,
   output logic        bus_write,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_busy,
   output logic        io_sel,
   input  logic [31:0] io_rdata,
   output logic        stall
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      IO_ACC = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state_r;
   logic             last_data_r;
   logic             grant_data_r;
   logic             write_r;
   logic [CNT_W-1:0] cnt_r;

   logic data_req_s;
   logic io_hit_s;
   logic data_win_s;
   logic own_req_s;
   logic tmo_s;
   logic issue_s;

   // Request decode; the strobe is gated by bus_busy so it never fires into a busy bus
   always_comb begin
      data_req_s = d_read | d_write;
      io_hit_s   = data_req_s & (d_addr >= IO_BASE);
      data_win_s = data_req_s & (~i_req | ~last_data_r);
      own_req_s  = grant_data_r ? data_req_s : i_req;
      tmo_s      = (cnt_r == CNT_W'(TIMEOUT - 1));
      issue_s    = (state_r == ISSUE) & ~bus_busy;
      bus_read   = issue_s & ~write_r;
      bus_write  = issue_s & write_r;
      stall      = (i_req & ~i_ack) | (data_req_s & ~d_ack);
   end

   // Transaction sequencer: grant, issue, wait/timeout, IO access and ack
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         last_data_r  <= 1'b0;
         grant_data_r <= 1'b0;
         write_r      <= 1'b0;
         cnt_r        <= {CNT_W{1'b0}};
         i_rdata      <= 32'h0;
         d_rdata      <= 32'h0;
         i_ack        <= 1'b0;
         d_ack        <= 1'b0;
         err          <= 1'b0;
         bus_addr     <= 32'h0;
         bus_wdata    <= 32'h0;
         io_sel       <= 1'b0;
      end else begin
         i_ack  <= 1'b0;
         d_ack  <= 1'b0;
         err    <= 1'b0;
         io_sel <= 1'b0;
         case (state_r)
            IDLE: begin
               if (io_hit_s) begin
                  grant_data_r <= 1'b1;
                  write_r      <= d_write;
                  io_sel       <= 1'b1;
                  state_r      <= IO_ACC;
               end else if (data_win_s) begin
                  grant_data_r <= 1'b1;
                  write_r      <= d_write;
                  bus_addr     <= d_addr;
                  bus_wdata    <= d_wdata;
                  state_r      <= ISSUE;
               end else if (i_req) begin
                  grant_data_r <= 1'b0;
                  write_r      <= 1'b0;
                  bus_addr     <= i_addr;
                  bus_wdata    <= 32'h0;
                  state_r      <= ISSUE;
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               if (!bus_busy) begin
                  state_r <= WAIT;
               end else if (tmo_s) begin
                  cnt_r   <= cnt_r + CNT_W'(1);
                  i_ack   <= own_req_s & ~grant_data_r;
                  d_ack   <= own_req_s & grant_data_r;
                  err     <= own_req_s;
                  state_r <= DONE;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            WAIT: begin
               if (!bus_busy) begin
                  if (grant_data_r) begin
                     d_rdata <= bus_rdata;
                  end else begin
                     i_rdata <= bus_rdata;
                  end
                  i_ack   <= own_req_s & ~grant_data_r;
                  d_ack   <= own_req_s & grant_data_r;
                  state_r <= DONE;
               end else if (tmo_s) begin
                  cnt_r   <= cnt_r + CNT_W'(1);
                  i_ack   <= own_req_s & ~grant_data_r;
                  d_ack   <= own_req_s & grant_data_r;
                  err     <= own_req_s;
                  state_r <= DONE;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            IO_ACC: begin
               if (!write_r) begin
                  d_rdata <= io_rdata;
               end else begin
                  d_rdata <= d_rdata;
               end
               d_ack   <= own_req_s;
               state_r <= DONE;
            end
            DONE: begin
               last_data_r <= grant_data_r;
               cnt_r       <= {CNT_W{1'b0}};
               state_r     <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
